// File: rtl/date_pkg.sv
// Shared date encodings for the set-mode controller, day/month/year counters and scan stage.
// Holds mode codes, the reset date 00/01/01, month lengths and the month-length helper.
package date_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_YEAR  = 2'd1,
    MODE_MONTH = 2'd2,
    MODE_DAY   = 2'd3
  } set_mode_t;

  localparam logic [3:0] RST_YEAR1  = 4'd0;
  localparam logic [3:0] RST_YEAR0  = 4'd0;
  localparam logic [3:0] RST_MONTH1 = 4'd0;
  localparam logic [3:0] RST_MONTH0 = 4'd1;
  localparam logic [3:0] RST_DAY1   = 4'd0;
  localparam logic [3:0] RST_DAY0   = 4'd1;

  localparam logic [7:0] DAYS_28 = 8'h28;
  localparam logic [7:0] DAYS_29 = 8'h29;
  localparam logic [7:0] DAYS_30 = 8'h30;
  localparam logic [7:0] DAYS_31 = 8'h31;

  // Years 2000-2099: divisible by 4 expressed directly on the BCD digits.
  function automatic logic is_leap(logic [3:0] y1, logic [3:0] y0);
    if (y1[0]) return (y0 == 4'd2) || (y0 == 4'd6);
    else       return (y0 == 4'd0) || (y0 == 4'd4) || (y0 == 4'd8);
  endfunction

  function automatic logic [7:0] month_max(logic [3:0] m1, logic [3:0] m0,
                                           logic [3:0] y1, logic [3:0] y0);
    case ({m1, m0})
      8'h02:                      return is_leap(y1, y0) ? DAYS_29 : DAYS_28;
      8'h04, 8'h06, 8'h09, 8'h11: return DAYS_30;
      default:                    return DAYS_31;
    endcase
  endfunction

endpackage

// File: rtl/date_set_ctl_if.sv
// Button inputs and edited-date outputs of the set-mode controller.
// master = controller side, slave = counter chain / scan stage / button source.
interface date_set_ctl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [1:0] set_mode;
  logic       load;
  logic [3:0] year1, year0;
  logic [3:0] month1, month0;
  logic [3:0] day1, day0;
  logic       blink;

  modport master (
    input  btn_mode, btn_inc,
    output set_mode, load, year1, year0, month1, month0, day1, day0, blink
  );

  modport slave (
    output btn_mode, btn_inc,
    input  set_mode, load, year1, year0, month1, month0, day1, day0, blink
  );
endinterface

// File: rtl/btn_debounce_pulse.sv
// Purpose: 2-FF synchronizer, DEB_CYCLES debounce and rising-edge pulse for one raw button.
// Latency: pulse about DEB_CYCLES+3 cycles after a clean press; one cycle wide.
// Backpressure: none, the pulse is fire-and-forget.
module btn_debounce_pulse #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync0, sync1, level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
      pulse <= 1'b0;
      if (sync1 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync1;
        cnt   <= '0;
        pulse <= sync1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/date_set_ctl.sv
// Purpose: mode/inc buttons -> edited BCD date, field select, blink and load strobe (DATE_SET_BLINK_EN adds blink).
// Latency: digits update the cycle after a button pulse; day clamp one cycle after a year/month change.
// Backpressure: none; load is a single-cycle strobe the counters must take.
module date_set_ctl
  import date_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int BLINK_DIV  = 24
) (
  input  logic clk,
  input  logic rst,
  date_set_ctl_if.master bus
);
  logic       mode_p, inc_p;
  set_mode_t  mode_q;
  logic       load_q, clamp_pend;
  logic [3:0] y1, y0, m1, m0, d1, d0;
  logic [7:0] day_max;

  btn_debounce_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_mode_btn (
    .clk(clk), .rst(rst), .btn(bus.btn_mode), .pulse(mode_p)
  );
  btn_debounce_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_inc_btn (
    .clk(clk), .rst(rst), .btn(bus.btn_inc), .pulse(inc_p)
  );

  assign day_max = month_max(m1, m0, y1, y0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= MODE_RUN;
      load_q     <= 1'b0;
      clamp_pend <= 1'b0;
      {y1, y0}   <= {RST_YEAR1, RST_YEAR0};
      {m1, m0}   <= {RST_MONTH1, RST_MONTH0};
      {d1, d0}   <= {RST_DAY1, RST_DAY0};
    end else begin
      load_q     <= 1'b0;
      clamp_pend <= 1'b0;
      if (clamp_pend && ({d1, d0} > day_max))
        {d1, d0} <= day_max;
      // Mode wins over a coincident increment.
      if (mode_p) begin
        case (mode_q)
          MODE_RUN:   mode_q <= MODE_YEAR;
          MODE_YEAR:  mode_q <= MODE_MONTH;
          MODE_MONTH: mode_q <= MODE_DAY;
          default: begin
            mode_q <= MODE_RUN;
            load_q <= 1'b1;
          end
        endcase
      end else if (inc_p) begin
        case (mode_q)
          MODE_YEAR: begin
            clamp_pend <= 1'b1;
            if (y0 == 4'd9) begin
              y0 <= 4'd0;
              y1 <= (y1 == 4'd9) ? 4'd0 : y1 + 4'd1;
            end else begin
              y0 <= y0 + 4'd1;
            end
          end
          MODE_MONTH: begin
            clamp_pend <= 1'b1;
            if ({m1, m0} == 8'h12)   {m1, m0} <= 8'h01;
            else if (m0 == 4'd9)     {m1, m0} <= 8'h10;
            else                     m0 <= m0 + 4'd1;
          end
          MODE_DAY: begin
            if ({d1, d0} >= day_max) {d1, d0} <= 8'h01;
            else if (d0 == 4'd9) begin
              d0 <= 4'd0;
              d1 <= d1 + 4'd1;
            end else begin
              d0 <= d0 + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.set_mode = mode_q;
  assign bus.load     = load_q;
  assign bus.year1    = y1;
  assign bus.year0    = y0;
  assign bus.month1   = m1;
  assign bus.month0   = m0;
  assign bus.day1     = d1;
  assign bus.day0     = d0;

`ifdef DATE_SET_BLINK_EN
  logic [BLINK_DIV:0] blink_cnt;
  logic               blink_q;

  // Restart on every field change so the newly selected field starts visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (mode_p || (mode_q == MODE_RUN)) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      blink_q   <= blink_cnt[BLINK_DIV];
    end
  end

  assign bus.blink = blink_q;
`else
  // Always 0 for any legal BLINK_DIV; keeps the parameter referenced in this build.
  assign bus.blink = (BLINK_DIV < 0);
`endif
endmodule
